// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants and types for the 5-stage RV32I pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- canonical bubble instruction
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // Fetch-stage controller states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    BUF   = 2'd2,
    DRAIN = 2'd3
  } if_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : Pipeline register {instr, pc, pc+4, valid} with flush/load/hold.
//            Flush wins over load; neither means hold.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] FLUSH_INSTR = NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic            valid_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid_out
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // Select next register contents: flush to a bubble, load new, or hold
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = FLUSH_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = valid_in;
    end
  end

  // Register storage with asynchronous reset to a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= FLUSH_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch with PC, skid buffer, redirect drain and the
//            IF/ID pipeline register. Drives a variable-latency req/ready
//            instruction memory; request and address are registered.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [riscv_pkg::XLEN-1:0] NOP      = riscv_pkg::NOP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       StallF,
  input  logic                       StallD,
  input  logic                       PCSrcD,
  input  logic [riscv_pkg::XLEN-1:0] PCBranchD,
  output logic                       imem_req,
  output logic [riscv_pkg::XLEN-1:0] imem_addr,
  input  logic [riscv_pkg::XLEN-1:0] imem_rdata,
  input  logic                       imem_ready,
  output logic [riscv_pkg::XLEN-1:0] InstrD,
  output logic [riscv_pkg::XLEN-1:0] PCD,
  output logic [riscv_pkg::XLEN-1:0] PCPlus4D,
  output logic                       ValidD,
  output logic [riscv_pkg::XLEN-1:0] FetchStallCnt
);

  import riscv_pkg::XLEN;
  import riscv_pkg::if_state_t;
  import riscv_pkg::BOOT;
  import riscv_pkg::FETCH;
  import riscv_pkg::BUF;
  import riscv_pkg::DRAIN;

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic [XLEN-1:0] stale_q, stale_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;

  logic            avail;
  logic [XLEN-1:0] avail_instr;
  logic            redirect;
  logic            advance;
  logic            id_load;
  logic            id_flush;
  logic [XLEN-1:0] pcf_plus4;

  assign avail       = ((state_q == FETCH) && imem_ready) || (state_q == BUF);
  assign avail_instr = (state_q == BUF) ? skid_q : imem_rdata;
  // A branch held in decode by a stall must not redirect yet
  assign redirect    = PCSrcD && !StallD;
  assign advance     = avail && !StallF && !StallD && !redirect;
  assign pcf_plus4   = pcf_q + 32'd4;

  // Next-state: redirect beats advance beats hold; bubble when starved
  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    skid_d   = skid_q;
    stale_d  = stale_q;
    cnt_d    = cnt_q;
    id_load  = 1'b0;
    id_flush = 1'b0;

    if (redirect) begin
      pcf_d    = PCBranchD;
      id_flush = 1'b1;
      case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: begin
          if (!imem_ready) begin
            // The outstanding request still has to complete; remember it
            stale_d = pcf_q;
            state_d = DRAIN;
          end
        end
        BUF:   state_d = FETCH;
        DRAIN: if (imem_ready) state_d = FETCH;
        default: state_d = BOOT;
      endcase
    end else if (advance) begin
      id_load = 1'b1;
      pcf_d   = pcf_plus4;
      state_d = FETCH;
    end else if (avail) begin
      // Stalled with an instruction in hand: park it in the skid buffer
      if (state_q == FETCH) skid_d = imem_rdata;
      state_d = BUF;
    end else begin
      if (!StallD) id_flush = 1'b1;
      case (state_q)
        BOOT:    state_d = FETCH;
        DRAIN:   if (imem_ready) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end

    if (!StallD && !avail && (state_q != BOOT) && (cnt_q != '1))
      cnt_d = cnt_q + 32'd1;

    // Memory-side outputs derive from the next state only (Moore)
    imem_req_d  = (state_d == FETCH) || (state_d == DRAIN);
    imem_addr_d = (state_d == DRAIN) ? stale_d : pcf_d;
  end

  // Controller state, PC, buffers, counter and registered memory outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pcf_q       <= RESET_PC;
      skid_q      <= NOP;
      stale_q     <= '0;
      cnt_q       <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      skid_q      <= skid_d;
      stale_q     <= stale_d;
      cnt_q       <= cnt_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  if_id_reg #(
    .FLUSH_INSTR (NOP)
  ) u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (id_load),
    .flush        (id_flush),
    .instr_in     (avail_instr),
    .pc_in        (pcf_q),
    .pc_plus4_in  (pcf_plus4),
    .valid_in     (1'b1),
    .instr_out    (InstrD),
    .pc_out       (PCD),
    .pc_plus4_out (PCPlus4D),
    .valid_out    (ValidD)
  );

  assign imem_req      = imem_req_q;
  assign imem_addr     = imem_addr_q;
  assign FetchStallCnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed stimulus, expected
//            decode stream queued by the stimulus, popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] MAGIC = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] InstrD, PCD, PCPlus4D, FetchStallCnt;
  logic        ValidD;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP      (NOP_I)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .StallD        (StallD),
    .PCSrcD        (PCSrcD),
    .PCBranchD     (PCBranchD),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .ValidD        (ValidD),
    .FetchStallCnt (FetchStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ready on the (mem_wait+1)th cycle of a held request
  int mem_cnt;
  int mem_wait;
  int fetch8;
  assign imem_ready = imem_req && (mem_cnt == mem_wait);
  assign imem_rdata = imem_addr ^ MAGIC;

  always @(posedge clk or posedge rst) begin
    if (rst) mem_cnt <= 0;
    else if (imem_req && !imem_ready) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst && imem_req && imem_ready && imem_addr == 32'h8) fetch8 <= fetch8 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " imem_req"},      {31'd0, imem_req}, 32'd0);
    check({tag, " imem_addr"},     imem_addr, 32'h0);
    check({tag, " InstrD"},        InstrD, NOP_I);
    check({tag, " PCD"},           PCD, 32'h0);
    check({tag, " PCPlus4D"},      PCPlus4D, 32'h0);
    check({tag, " ValidD"},        {31'd0, ValidD}, 32'd0);
    check({tag, " FetchStallCnt"}, FetchStallCnt, 32'd0);
  endtask

  // Monitor: each newly loaded valid IF/ID entry is matched against the queue
  logic        prev_v;
  logic [31:0] prev_pc;
  initial begin
    prev_v  = 1'b0;
    prev_pc = '0;
  end
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (ValidD && !(prev_v && PCD == prev_pc)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr_pcd", PCD, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("mon_PCD",      PCD, e);
          check("mon_InstrD",   InstrD, e ^ MAGIC);
          check("mon_PCPlus4D", PCPlus4D, e + 32'd4);
        end
      end
      prev_v  = ValidD;
      prev_pc = PCD;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PCSrcD = 1'b0; PCBranchD = '0; StallF = 1'b0; StallD = 1'b0;
    mem_wait = 0; fetch8 = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");

    exp_q.push_back(32'h000); exp_q.push_back(32'h004);
    exp_q.push_back(32'h008); exp_q.push_back(32'h00C);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
    rst = 1'b0;

    // Boot cycle, then zero-wait streaming
    tick();
    check("boot_validd", {31'd0, ValidD}, 32'd0);
    check("boot_req",    {31'd0, imem_req}, 32'd1);
    tick();
    check("first_pcd_latency", PCD, 32'h0);
    check("first_validd", {31'd0, ValidD}, 32'd1);
    tick();

    // Stall both at PCF=8: instruction parks in the skid buffer
    StallF = 1'b1; StallD = 1'b1;
    tick();
    check("buf_req_low", {31'd0, imem_req}, 32'd0);
    tick(); tick();
    check("stall_hold_pcd", PCD, 32'h4);
    check("stall_req_low",  {31'd0, imem_req}, 32'd0);
    StallF = 1'b0; StallD = 1'b0;
    tick();
    check("release_pcd", PCD, 32'h8);
    tick();
    check("no_refetch_8", fetch8, 32'd1);
    check("cnt_zero_wait", FetchStallCnt, 32'd0);

    // Branch held in decode by a stall must not redirect
    PCSrcD = 1'b1; PCBranchD = 32'h200; StallF = 1'b1; StallD = 1'b1;
    tick();
    check("held_branch_pcd",  PCD, 32'hC);
    check("held_branch_addr", imem_addr, 32'h10);
    StallF = 1'b0; StallD = 1'b0;
    tick();
    check("redirect_validd", {31'd0, ValidD}, 32'd0);
    check("redirect_instrd", InstrD, NOP_I);
    check("redirect_addr",   imem_addr, 32'h200);
    PCSrcD = 1'b0;
    tick();

    // Two-wait memory, redirect while a fetch is outstanding
    mem_wait = 2;
    tick(); tick();
    check("wait2_bubble", {31'd0, ValidD}, 32'd0);
    check("wait2_cnt",    FetchStallCnt, 32'd2);
    tick();
    PCSrcD = 1'b1; PCBranchD = 32'h100;
    tick();
    PCSrcD = 1'b0;
    check("drain_req",    {31'd0, imem_req}, 32'd1);
    check("drain_addr",   imem_addr, 32'h208);
    check("drain_validd", {31'd0, ValidD}, 32'd0);
    tick();
    check("drain_addr_stable", imem_addr, 32'h208);
    tick();
    check("post_drain_addr",   imem_addr, 32'h100);
    check("post_drain_validd", {31'd0, ValidD}, 32'd0);
    tick(); tick(); tick();
    check("target_pcd", PCD, 32'h100);
    check("target_cnt", FetchStallCnt, 32'd7);

    // Three-wait memory: 4 cycles per instruction, 3 bubbles each
    mem_wait = 3;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 3; b++) begin
        tick();
        check("wait3_bubble", {31'd0, ValidD}, 32'd0);
      end
      tick();
      check("wait3_valid", {31'd0, ValidD}, 32'd1);
      check("wait3_cnt",   FetchStallCnt, 32'd7 + 32'(3 * (k + 1)));
    end

    // Reset asserted mid-drain acts without a clock edge
    PCSrcD = 1'b1; PCBranchD = 32'h300;
    tick();
    PCSrcD = 1'b0;
    check("pre_rst_drain_addr", imem_addr, 32'h110);
    check("pre_rst_drain_req",  {31'd0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    mem_wait = 0;
    exp_q.push_back(32'h000); exp_q.push_back(32'h004);
    rst = 1'b0;
    tick();
    check("restart_addr", imem_addr, 32'h0);
    check("restart_req",  {31'd0, imem_req}, 32'd1);
    tick();
    check("restart_pcd", PCD, 32'h0);
    tick();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
